// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: drains it through rd/empty/data and
// re-emits the words as a valid/ready stream framed into BURST_LEN-beat packets.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      words_sent,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [7:0]       rd_beat_q, rd_beat_d;
  logic [7:0]       tx_beat_q, tx_beat_d;
  logic [15:0]      words_sent_q;
  logic [WIDTH-1:0] mem_q [3];
  logic [WIDTH-1:0] mem_d [3];
  logic             push;
  logic             pop;
  logic             hold_packet;
  logic [1:0]       wr_idx;

  assign push = inflight_q;
  assign pop  = m_valid && m_ready;
  // Packets close only on a read boundary, so a late enable drop still completes one.
  assign hold_packet = !enable && (rd_beat_q == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (hold_packet) state_d = DRAIN;
      DRAIN: begin
        if (enable)                            state_d = RUN;
        else if (!inflight_q && occ_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads look only at registered occupancy so m_ready never reaches fifo_rd.
  always_comb begin
    fifo_rd = (state_q == RUN) && !fifo_empty &&
              (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2) && !hold_packet;
    busy    = (state_q != IDLE) || (occ_q != 2'd0);
  end

  always_comb begin
    rd_beat_d = rd_beat_q;
    tx_beat_d = tx_beat_q;
    if (fifo_rd) rd_beat_d = (rd_beat_q == LAST_BEAT) ? 8'd0 : rd_beat_q + 8'd1;
    if (pop)     tx_beat_d = (tx_beat_q == LAST_BEAT) ? 8'd0 : tx_beat_q + 8'd1;
  end

  always_comb begin
    mem_d  = mem_q;
    occ_d  = occ_q;
    wr_idx = pop ? occ_q - 2'd1 : occ_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
    end
    if (push && wr_idx != 2'd3) mem_d[wr_idx] = fifo_data;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (!push && pop) occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      rd_beat_q    <= 8'd0;
      tx_beat_q    <= 8'd0;
      words_sent_q <= 16'd0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      assert (!(push && !pop && occ_q == 2'd3));
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
      rd_beat_q  <= rd_beat_d;
      tx_beat_q  <= tx_beat_d;
      mem_q      <= mem_d;
      if (pop) words_sent_q <= words_sent_q + 16'd1;
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = m_valid ? mem_q[0] : '0;
  assign m_last     = m_valid && (tx_beat_q == LAST_BEAT);
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue models the FIFO and a second
// queue holds the words the stream must deliver, in order.
module tb_fifo_stream_reader;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] words_sent;
  logic        busy;

  logic        en1, empty1, rdy1;
  logic [7:0]  data1;
  logic        rd1, valid1, last1, busy1;
  logic [7:0]  mdata1;
  logic [15:0] sent1;

  logic [7:0]  fifoQ[$];
  logic [7:0]  expQ[$];
  int          txIdx, txCount, rdCount, cycleNo;
  logic [15:0] sentCount;
  int          assertCount, failCount;
  logic        obsRd, obsValid, obsXfer, obsBusy;

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .words_sent(words_sent), .busy(busy)
  );

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(empty1),
    .fifo_data(data1), .fifo_rd(rd1), .m_valid(valid1), .m_ready(rdy1),
    .m_data(mdata1), .m_last(last1), .words_sent(sent1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable  = en;
    m_ready = rdy;
  endtask

  task automatic pushWord(input logic [7:0] w);
    fifoQ.push_back(w);
    expQ.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: observe at the falling edge, then model the FIFO after the rising edge.
  task automatic cycle();
    @(negedge clk);
    cycleNo++;
    obsRd    = fifo_rd;
    obsValid = m_valid;
    obsBusy  = busy;
    obsXfer  = 1'b0;
    checkOutput("words_sent", words_sent, sentCount);
    if (fifo_rd) checkOutput("rd_while_empty", fifo_empty, 0);
    if (m_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", m_valid, 0);
      end else begin
        checkOutput("m_data", m_data, expQ[0]);
        checkOutput("m_last", m_last, (txIdx % BURST) == (BURST - 1));
        if (m_ready) begin
          expQ.delete(0);
          obsXfer = 1'b1;
          txIdx++;
          txCount++;
          sentCount++;
        end
      end
    end else begin
      checkOutput("m_last_idle", m_last, 0);
    end
    if (obsRd) rdCount++;
    @(posedge clk);
    #1;
    if (obsRd && fifoQ.size() > 0) begin
      fifo_data = fifoQ[0];
      fifoQ.delete(0);
    end
    fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic waitIdle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (!obsBusy) break;
    end
    checkOutput(tag, obsBusy, 0);
  endtask

  initial begin
    int firstRd, firstValid, firstXfer, lastXfer, rdStart, vCount, done;
    logic chk0;
    assertCount = 0; failCount = 0; txIdx = 0; txCount = 0; rdCount = 0;
    cycleNo = 0; sentCount = 16'd0;
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    applyStimulus(1'b0, 1'b0);
    en1 = 1'b0; empty1 = 1'b0; rdy1 = 1'b1; data1 = 8'h3C;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_fifo_rd", fifo_rd, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_words_sent", words_sent, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // One packet, ready held high
    $display("[TB] single packet");
    for (int k = 0; k < 4; k++) pushWord(8'hA0 + 8'(k));
    applyStimulus(1'b1, 1'b1);
    firstRd = -1; firstValid = -1; firstXfer = -1; lastXfer = -1;
    for (int i = 0; i < 30 && txCount < 4; i++) begin
      cycle();
      if (obsRd && firstRd < 0) firstRd = cycleNo;
      if (obsValid && firstValid < 0) firstValid = cycleNo;
      if (obsXfer) begin
        if (firstXfer < 0) firstXfer = cycleNo;
        lastXfer = cycleNo;
      end
    end
    checkOutput("t1_transfers", txCount, 4);
    checkOutput("t1_latency", firstValid - firstRd, 2);
    checkOutput("t1_back_to_back", lastXfer - firstXfer, 3);
    checkOutput("t1_words_sent", words_sent, 4);
    applyStimulus(1'b0, 1'b1);
    waitIdle("t1_idle", 30);

    // Backpressure: ready pattern 1,0,0 over two packets
    $display("[TB] backpressure");
    txCount = 0;
    for (int k = 0; k < 8; k++) pushWord(8'hB0 + 8'(k));
    enable = 1'b1;
    for (int i = 0; i < 150 && txCount < 8; i++) begin
      m_ready = (i % 3 == 0);
      cycle();
    end
    checkOutput("t2_transfers", txCount, 8);
    checkOutput("t2_words_sent", words_sent, 12);
    applyStimulus(1'b0, 1'b1);
    waitIdle("t2_idle", 30);

    // Enable dropped mid-packet with six words available
    $display("[TB] enable drop mid-packet");
    txCount = 0;
    rdStart = rdCount;
    for (int k = 0; k < 6; k++) pushWord(8'hC0 + 8'(k));
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 30 && (rdCount - rdStart) < 2; i++) cycle();
    enable = 1'b0;
    waitIdle("t3_idle", 40);
    checkOutput("t3_reads", rdCount - rdStart, 4);
    checkOutput("t3_transfers", txCount, 4);
    checkOutput("t3_fifo_left", fifoQ.size(), 2);

    // Asynchronous reset while two words sit in the buffer
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b0);
    repeat (6) cycle();
    checkOutput("t4_valid_before", m_valid, 1);
    checkOutput("t4_data_before", m_data, 8'hC4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_valid", m_valid, 0);
    checkOutput("t4_rst_data", m_data, 0);
    checkOutput("t4_rst_last", m_last, 0);
    checkOutput("t4_rst_rd", fifo_rd, 0);
    checkOutput("t4_rst_busy", busy, 0);
    checkOutput("t4_rst_sent", words_sent, 0);
    fifoQ.delete(); expQ.delete();
    fifo_empty = 1'b1; txIdx = 0; sentCount = 16'd0;
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) cycle();
    checkOutput("t4_idle_busy", busy, 0);
    checkOutput("t4_idle_valid", m_valid, 0);

    // Underrun: three words, the fourth arrives late
    $display("[TB] underrun");
    txCount = 0;
    for (int k = 0; k < 3; k++) pushWord(8'hD0 + 8'(k));
    applyStimulus(1'b1, 1'b1);
    repeat (12) cycle();
    checkOutput("t5_three_sent", txCount, 3);
    checkOutput("t5_still_busy", busy, 1);
    checkOutput("t5_gap_valid", m_valid, 0);
    pushWord(8'hD3);
    for (int i = 0; i < 20 && txCount < 4; i++) cycle();
    checkOutput("t5_fourth", txCount, 4);
    applyStimulus(1'b0, 1'b1);
    waitIdle("t5_idle", 30);

    // Single-beat packets
    $display("[TB] BURST_LEN=1 instance");
    en1 = 1'b1;
    vCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid1) begin
        checkOutput("b1_last", last1, 1);
        checkOutput("b1_data", mdata1, 8'h3C);
        vCount++;
      end else begin
        checkOutput("b1_last_idle", last1, 0);
      end
      rdy1 = ~rdy1;
    end
    checkOutput("b1_beats_seen", vCount > 0, 1);

    // words_sent wrap
    $display("[TB] words_sent wrap");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    fifo_empty = 1'b0; fifo_data = 8'h77;
    applyStimulus(1'b1, 1'b1);
    done = 0; chk0 = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (done == 65536 && !chk0) begin
        checkOutput("wrap_zero", words_sent, 0);
        chk0 = 1'b1;
      end
      if (done == 65537) break;
      if (m_valid && m_ready) done++;
    end
    checkOutput("wrap_count", done, 65537);
    checkOutput("wrap_one", words_sent, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
